// File: rtl/cmp_window_stats_pkg.sv
// Shared types and constants for the compare-window statistics block:
// FSM state encoding, comparator flag codes and a one-hot helper.
package cmp_window_stats_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  // Flag codes packed as {a_greater, a_equal, a_less}
  localparam logic [2:0] FLG_GT = 3'b100;
  localparam logic [2:0] FLG_EQ = 3'b010;
  localparam logic [2:0] FLG_LT = 3'b001;

  function automatic logic is_one_hot(input logic [2:0] code);
    return (code == FLG_GT) || (code == FLG_EQ) || (code == FLG_LT);
  endfunction

endpackage

// File: rtl/cmp_window_stats_if.sv
// Flag-sample input stream and report output stream of cmp_window_stats.
// master = producer/consumer side, slave = the statistics block.
interface cmp_window_stats_if #(
    parameter int WINDOW = 8
);
    localparam int CNT_W = $clog2(WINDOW + 1);

    logic             in_valid;
    logic             in_ready;
    logic             a_greater;
    logic             a_equal;
    logic             a_less;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] gt_count;
    logic [CNT_W-1:0] eq_count;
    logic [CNT_W-1:0] lt_count;
    logic [CNT_W-1:0] err_count;

    modport master (
        output in_valid, a_greater, a_equal, a_less, out_ready,
        input  in_ready, out_valid, gt_count, eq_count, lt_count, err_count
    );

    modport slave (
        input  in_valid, a_greater, a_equal, a_less, out_ready,
        output in_ready, out_valid, gt_count, eq_count, lt_count, err_count
    );
endinterface

// File: rtl/cmp_window_stats_counter.sv
// Saturation-free tally counter: synchronous clear has priority over increment.
module cmp_stat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end
endmodule

// File: rtl/cmp_window_stats.sv
// Tallies comparator outcomes over WINDOW accepted samples and holds one
// report of greater/equal/less/error counts until the consumer takes it.
module cmp_window_stats
    import cmp_window_stats_pkg::*;
#(
    parameter int WINDOW = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    cmp_window_stats_if.slave   bus,
    output state_t              state_dbg
);
    localparam int CNT_W = $clog2(WINDOW + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high; ready never depends on valid, and valid holds until taken.
    state_t           state, state_nx;
    logic [CNT_W-1:0] sample_cnt;
    logic [2:0]       code;
    logic             accept;
    logic             handshake;
    logic             tally;

    assign code         = {bus.a_greater, bus.a_equal, bus.a_less};
    assign bus.in_ready = (state != ST_REPORT);
    assign bus.out_valid = (state == ST_REPORT);
    assign accept       = bus.in_valid & bus.in_ready;
    assign handshake    = bus.out_valid & bus.out_ready;
    assign tally        = accept & ~clear;
    assign state_dbg    = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) state_nx = (WINDOW == 1) ? ST_REPORT : ST_ACCUM;
            end
            ST_ACCUM: begin
                if (accept && sample_cnt == LAST_IDX) state_nx = ST_REPORT;
            end
            ST_REPORT: begin
                if (bus.out_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        // Abort wins over both accept and a completing report handshake
        if (clear) state_nx = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
        end else if (clear || handshake) begin
            sample_cnt <= '0;
        end else if (accept) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
        end
    end

    cmp_stat_counter #(.W(CNT_W)) u_gt (
        .clk(clk), .rst(rst), .clr(clear | handshake),
        .inc(tally & (code == FLG_GT)), .count(bus.gt_count)
    );
    cmp_stat_counter #(.W(CNT_W)) u_eq (
        .clk(clk), .rst(rst), .clr(clear | handshake),
        .inc(tally & (code == FLG_EQ)), .count(bus.eq_count)
    );
    cmp_stat_counter #(.W(CNT_W)) u_lt (
        .clk(clk), .rst(rst), .clr(clear | handshake),
        .inc(tally & (code == FLG_LT)), .count(bus.lt_count)
    );
    cmp_stat_counter #(.W(CNT_W)) u_err (
        .clk(clk), .rst(rst), .clr(clear | handshake),
        .inc(tally & ~is_one_hot(code)), .count(bus.err_count)
    );
endmodule

// File: tb/tb_cmp_window_stats.sv
// Bench for cmp_window_stats: table-driven windows, hand corner sequences,
// and randomized traffic checked against a queue-based window model.
module tb_cmp_window_stats;
  import cmp_window_stats_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  logic   clear8;
  logic   clear1;
  state_t st8;
  state_t st1;
  int     errors = 0;
  int     checks = 0;

  always #5 clk = ~clk;

  cmp_window_stats_if #(.WINDOW(8)) if8 ();
  cmp_window_stats_if #(.WINDOW(1)) if1 ();

  cmp_window_stats #(.WINDOW(8)) dut8 (
    .clk(clk), .rst(rst), .clear(clear8), .bus(if8), .state_dbg(st8)
  );
  cmp_window_stats #(.WINDOW(1)) dut1 (
    .clk(clk), .rst(rst), .clear(clear1), .bus(if1), .state_dbg(st1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model for the WINDOW=8 instance ----------------
  logic [2:0] mq[$];   // flag codes accepted in the current window
  bit         m_pend;  // a complete window is waiting to be taken

  task automatic model_reset();
    mq.delete();
    m_pend = 0;
  endtask

  task automatic check8();
    int gt = 0, eq = 0, lt = 0, er = 0;
    foreach (mq[i]) begin
      if ($countones(mq[i]) != 1) er++;
      else if (mq[i] == 3'b100)   gt++;
      else if (mq[i] == 3'b010)   eq++;
      else                        lt++;
    end
    chk("in_ready",  int'(if8.in_ready),  int'(!m_pend));
    chk("out_valid", int'(if8.out_valid), int'(m_pend));
    chk("gt_count",  int'(if8.gt_count),  gt);
    chk("eq_count",  int'(if8.eq_count),  eq);
    chk("lt_count",  int'(if8.lt_count),  lt);
    chk("err_count", int'(if8.err_count), er);
  endtask

  // One clock of WINDOW=8 traffic: entered and left at a falling edge.
  task automatic cyc8(input logic v, input logic [2:0] f, input logic ordy, input logic clr);
    check8();
    if8.in_valid = v;
    {if8.a_greater, if8.a_equal, if8.a_less} = f;
    if8.out_ready = ordy;
    clear8 = clr;
    @(posedge clk);
    if (clr) begin
      model_reset();
    end else if (m_pend) begin
      if (ordy) model_reset();
    end else if (v) begin
      mq.push_back(f);
      if (mq.size() == 8) m_pend = 1;
    end
    @(negedge clk);
  endtask

  task automatic idle8();
    if8.in_valid = 1'b0;
    if8.out_ready = 1'b0;
    {if8.a_greater, if8.a_equal, if8.a_less} = 3'b000;
    clear8 = 1'b0;
  endtask

  typedef struct {
    logic [2:0] flags [8];
    int gt, eq, lt, err;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0].flags = '{3'b100, 3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b001, 3'b001};
    vecs[0].gt = 3; vecs[0].eq = 2; vecs[0].lt = 3; vecs[0].err = 0;
    vecs[1].flags = '{3'b000, 3'b100, 3'b110, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
    vecs[1].gt = 6; vecs[1].eq = 0; vecs[1].lt = 0; vecs[1].err = 2;
    vecs[2].flags = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
    vecs[2].gt = 0; vecs[2].eq = 8; vecs[2].lt = 0; vecs[2].err = 0;
    vecs[3].flags = '{3'b001, 3'b011, 3'b111, 3'b010, 3'b100, 3'b001, 3'b001, 3'b101};
    vecs[3].gt = 1; vecs[3].eq = 1; vecs[3].lt = 3; vecs[3].err = 3;

    rst = 1'b1;
    idle8();
    clear1 = 1'b0;
    if1.in_valid = 1'b0;
    if1.out_ready = 1'b0;
    {if1.a_greater, if1.a_equal, if1.a_less} = 3'b000;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst in_ready8",  int'(if8.in_ready), 1);
    chk("rst out_valid8", int'(if8.out_valid), 0);
    chk("rst in_ready1",  int'(if1.in_ready), 1);
    chk("rst out_valid1", int'(if1.out_valid), 0);
    rst = 1'b0;
    @(negedge clk);

    // Table windows: back-to-back samples, then a 5-cycle stall with in_valid high
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < 8; s++) cyc8(1'b1, vecs[r].flags[s], 1'b0, 1'b0);
      chk("tbl out_valid", int'(if8.out_valid), 1);
      chk("tbl gt",  int'(if8.gt_count),  vecs[r].gt);
      chk("tbl eq",  int'(if8.eq_count),  vecs[r].eq);
      chk("tbl lt",  int'(if8.lt_count),  vecs[r].lt);
      chk("tbl err", int'(if8.err_count), vecs[r].err);
      for (int k = 0; k < 5; k++) cyc8(1'b1, 3'b100, 1'b0, 1'b0);
      chk("tbl held gt", int'(if8.gt_count), vecs[r].gt);
      chk("tbl held in_ready", int'(if8.in_ready), 0);
      cyc8(1'b0, 3'b000, 1'b1, 1'b0);
      chk("post hs in_ready", int'(if8.in_ready), 1);
      chk("post hs gt", int'(if8.gt_count), 0);
    end

    // Abort a partial window, offering a sample in the clear cycle
    for (int s = 0; s < 4; s++) cyc8(1'b1, 3'b100, 1'b0, 1'b0);
    cyc8(1'b1, 3'b010, 1'b0, 1'b1);
    for (int s = 0; s < 7; s++) cyc8(1'b1, 3'b010, 1'b0, 1'b0);
    chk("clr no early report", int'(if8.out_valid), 0);
    cyc8(1'b1, 3'b010, 1'b0, 1'b0);
    chk("clr report eq", int'(if8.eq_count), 8);
    chk("clr report gt", int'(if8.gt_count), 0);
    cyc8(1'b0, 3'b000, 1'b1, 1'b0);

    // Async reset mid-window and mid-report
    for (int rr = 0; rr < 2; rr++) begin
      for (int s = 0; s < (rr == 0 ? 3 : 8); s++) cyc8(1'b1, 3'b001, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("async rst lt",        int'(if8.lt_count), 0);
      chk("async rst out_valid", int'(if8.out_valid), 0);
      chk("async rst in_ready",  int'(if8.in_ready), 1);
      model_reset();
      idle8();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [2:0] f;
      logic v, o, c;
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) f = 3'($urandom_range(0, 7));
      else f = 3'b001 << $urandom_range(0, 2);
      o = ($urandom_range(0, 2) != 0);
      c = ($urandom_range(0, 40) == 0);
      cyc8(v, f, o, c);
    end
    check8();
    idle8();

    // WINDOW=1: report every other cycle with out_ready tied high
    if1.in_valid = 1'b1;
    {if1.a_greater, if1.a_equal, if1.a_less} = 3'b010;
    if1.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("w1 out_valid", int'(if1.out_valid), (k % 2 == 0) ? 1 : 0);
      chk("w1 eq",        int'(if1.eq_count),  (k % 2 == 0) ? 1 : 0);
      chk("w1 in_ready",  int'(if1.in_ready),  (k % 2 == 0) ? 0 : 1);
    end
    // Land in REPORT, then clear together with the handshake
    @(posedge clk);
    @(negedge clk);
    chk("w1 pre clr out_valid", int'(if1.out_valid), 1);
    clear1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear1 = 1'b0;
    if1.in_valid = 1'b0;
    chk("w1 clr out_valid", int'(if1.out_valid), 0);
    chk("w1 clr eq",        int'(if1.eq_count), 0);
    chk("w1 clr in_ready",  int'(if1.in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    chk("w1 idle out_valid", int'(if1.out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
